// File: rtl/vending_machine_basic.sv
// vending_machine_basic: 15-cent single-product coin vending controller
module vending_machine_basic (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic [1:0] coin,
  output logic       can,
  output logic [4:0] change,
  output logic [4:0] credit
);
  typedef enum logic [1:0] {S0 = 2'd0, S5 = 2'd1, S10 = 2'd2} state_t;
  state_t state, state_nx;
  logic [5:0] value, cur, sum;
  logic       can_nx;
  logic [4:0] change_nx;
  // state and vend outputs update on each edge; reset discards credit and any pending vend
  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      state  <= S0;
      can    <= 1'b0;
      change <= 5'd0;
    end else begin
      state  <= state_nx;
      can    <= can_nx;
      change <= change_nx;
    end
  end
  // add the coin to the held credit and vend once the price is reached
  always_comb begin
    value     = coin == 2'b01 ? 6'd5 : coin == 2'b10 ? 6'd10 : coin == 2'b11 ? 6'd25 : 6'd0;
    cur       = state == S5 ? 6'd5 : state == S10 ? 6'd10 : 6'd0;
    sum       = cur + value;
    can_nx    = sum >= 6'd15;
    change_nx = can_nx ? 5'(sum - 6'd15) : 5'd0;
    state_nx  = can_nx ? S0 : sum == 6'd5 ? S5 : sum == 6'd10 ? S10 : S0;
  end
  assign credit = cur[4:0];
endmodule

// File: tb/tb_vending_machine_basic.sv
// tb_vending_machine_basic: randomized scoreboard bench for the vending controller
module tb_vending_machine_basic;
  logic       clk = 1'b0;
  logic       sync_reset = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       can;
  logic [4:0] change, credit;

  typedef struct {
    logic       can;
    logic [4:0] change;
    logic [4:0] credit;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int m_credit = 0;
  int coin_cents[4] = '{0, 5, 10, 25};

  vending_machine_basic dut (
    .clk(clk),
    .sync_reset(sync_reset),
    .coin(coin),
    .can(can),
    .change(change),
    .credit(credit)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst_n, input logic [1:0] c);
    exp_t e;
    int total;
    @(negedge clk);
    sync_reset = rst_n;
    coin = c;
    e.can = 1'b0;
    e.change = 5'd0;
    if (!rst_n) begin
      m_credit = 0;
    end else begin
      total = m_credit + coin_cents[c];
      if (total >= 15) begin
        e.can = 1'b1;
        e.change = 5'(total - 15);
        m_credit = 0;
      end else begin
        m_credit = total;
      end
    end
    e.credit = 5'(m_credit);
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks += 3;
        if (can !== e.can) begin
          failures++;
          $display("FAIL can: got %b expected %b at %0t", can, e.can, $time);
        end
        if (change !== e.change) begin
          failures++;
          $display("FAIL change: got %0d expected %0d at %0t", change, e.change, $time);
        end
        if (credit !== e.credit) begin
          failures++;
          $display("FAIL credit: got %0d expected %0d at %0t", credit, e.credit, $time);
        end
      end
    end
  end

  initial begin
    repeat (5) step(1'b0, 2'b11);
    repeat (3) step(1'b1, 2'b00);
    step(1'b1, 2'b01); step(1'b1, 2'b10); step(1'b1, 2'b00);
    step(1'b1, 2'b10); step(1'b1, 2'b11); step(1'b1, 2'b00);
    step(1'b1, 2'b10); step(1'b0, 2'b00); step(1'b1, 2'b01); step(1'b1, 2'b00);
    step(1'b0, 2'b00);
    repeat (3) step(1'b1, 2'b11);
    step(1'b1, 2'b00);
    repeat (5) step(1'b1, 2'b01);
    step(1'b1, 2'b01); step(1'b0, 2'b00);
    step(1'b1, 2'b10); step(1'b1, 2'b11);
    step(1'b1, 2'b01); step(1'b1, 2'b01); step(1'b1, 2'b11);
    repeat (400) step($urandom_range(0, 19) != 0, 2'($urandom_range(0, 3)));
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
